// File: rtl/jtag_host_driver.sv
// jtag_host_driver: command-driven JTAG master.
// Accepts RESET / IR_SCAN / DR_SCAN / IDLE commands, walks the TAP from
// Run-Test/Idle back to Run-Test/Idle, and returns captured TDO bits.
// Optional feature macro: JTAG_DRV_TRST_EN -- when defined, a RESET command
// first drives trst low for two tck periods (tck toggling, tms=1).
module jtag_host_driver #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst,
  input  logic               tdo
);

  // Phase counter must also hold the longest preamble (6 reset + 4 IR = 10).
  localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_TRST, S_PRE, S_SHIFT, S_POST, S_RESP
  } state_t;

`ifdef JTAG_DRV_TRST_EN
  localparam bit TRST_EN = 1'b1;
  logic trst_q, trst_d;
`else
  localparam bit TRST_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               ph_q, ph_d;      // 0 = LOW phase, 1 = HIGH phase
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               synced_q, synced_d;
  logic [1:0]         op_q, op_d;
  logic               rs_q, rs_d;      // preamble starts with the 1,1,1,1,1,0 reset walk
  logic [CNT_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tick_end;
  logic               load;

  // Number of preamble tck cycles: optional reset walk, then the path to Shift-xR.
  function automatic logic [3:0] pre_len_f(input logic [1:0] op, input logic rs);
    logic [3:0] n;
    n = rs ? 4'd6 : 4'd0;
    if (op == OP_IR)      n = n + 4'd4;
    else if (op == OP_DR) n = n + 4'd3;
    return n;
  endfunction

  // TMS value for tck cycle 'c' of phase 's'.
  function automatic logic tms_f(input state_t s, input logic [CNT_W-1:0] c,
                                 input logic [1:0] op, input logic rs,
                                 input logic [CNT_W-1:0] len);
    logic             t;
    logic [CNT_W-1:0] j;
    t = 1'b1;
    j = rs ? c - CNT_W'(6) : c;
    case (s)
      S_TRST:  t = 1'b1;
      S_PRE: begin
        if (rs && (c < CNT_W'(6))) t = (c < CNT_W'(5));
        else if (op == OP_IR)      t = (j < CNT_W'(2));
        else                       t = (j == '0);
      end
      S_SHIFT: t = (op != OP_IDLE) && (c == len - CNT_W'(1));
      S_POST:  t = (c == '0);
      default: t = 1'b1;
    endcase
    return t;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      ph_q     <= 1'b0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      synced_q <= 1'b0;
      op_q     <= OP_RESET;
      rs_q     <= 1'b0;
      len_q    <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
`ifdef JTAG_DRV_TRST_EN
      trst_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      synced_q <= synced_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      len_q    <= len_d;
      data_q   <= data_d;
      rsp_q    <= rsp_d;
`ifdef JTAG_DRV_TRST_EN
      trst_q   <= trst_d;
`endif
    end
  end

  // Next-state: command accept, tck phase timing, phase sequencing, TDO capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    ph_d     = ph_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    synced_d = synced_q;
    op_d     = op_q;
    rs_d     = rs_q;
    len_d    = len_q;
    data_d   = data_q;
    rsp_d    = rsp_q;
    load     = 1'b0;
    tick_end = (div_q == DIV_W'(CLK_DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          rs_d     = (cmd_op == OP_RESET) || !synced_q;
          data_d   = cmd_data;
          rsp_d    = '0;
          synced_d = 1'b1;
          cnt_d    = '0;
          if (cmd_len == '0)                    len_d = CNT_W'(1);
          else if (cmd_len > LEN_W'(MAX_LEN))  len_d = CNT_W'(MAX_LEN);
          else                                  len_d = CNT_W'(cmd_len);
          if ((cmd_op == OP_RESET) && TRST_EN)  state_d = S_TRST;
          else if (pre_len_f(cmd_op, rs_d) != 4'd0) state_d = S_PRE;
          else                                  state_d = S_SHIFT;
          load = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        div_d = tick_end ? '0 : div_q + DIV_W'(1);
        if (tick_end && !ph_q) begin
          // This edge raises tck: capture TDO for the current shift bit.
          ph_d  = 1'b1;
          tck_d = 1'b1;
          if ((state_q == S_SHIFT) && (op_q != OP_IDLE))
            rsp_d[cnt_q[IDX_W-1:0]] = tdo;
        end else if (tick_end && ph_q) begin
          ph_d  = 1'b0;
          tck_d = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
          load  = 1'b1;
          case (state_q)
            S_TRST: if (cnt_q == CNT_W'(1)) begin
              cnt_d = '0; state_d = S_PRE;
            end
            S_PRE: if (cnt_q == CNT_W'(pre_len_f(op_q, rs_q)) - CNT_W'(1)) begin
              cnt_d = '0; state_d = (op_q == OP_RESET) ? S_RESP : S_SHIFT;
            end
            S_SHIFT: if (cnt_q == len_q - CNT_W'(1)) begin
              cnt_d = '0; state_d = (op_q == OP_IDLE) ? S_RESP : S_POST;
            end
            S_POST: if (cnt_q == CNT_W'(1)) begin
              cnt_d = '0; state_d = S_RESP;
            end
            default: ;
          endcase
          if (state_d == S_RESP) load = 1'b0;
        end
      end
    endcase

    // Start of a new LOW phase: present TMS/TDI for the upcoming tck cycle.
    if (load) begin
      div_d = '0;
      ph_d  = 1'b0;
      tck_d = 1'b0;
      tms_d = tms_f(state_d, cnt_d, op_d, rs_d, len_d);
      tdi_d = ((state_d == S_SHIFT) && (op_d != OP_IDLE)) ? data_d[cnt_d[IDX_W-1:0]] : 1'b0;
    end

`ifdef JTAG_DRV_TRST_EN
    trst_d = (state_d != S_TRST);
`endif
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
`ifdef JTAG_DRV_TRST_EN
  assign trst      = trst_q;
`else
  assign trst      = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver (CLK_DIV=2, MAX_LEN=32).
module tb_jtag_host_driver;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

`ifdef JTAG_DRV_TRST_EN
  localparam int          RST_TCK  = 8;
  localparam logic [63:0] RST_TMS  = 64'h7F;
  localparam int          TRST_LOW = 8;
`else
  localparam int          RST_TCK  = 6;
  localparam logic [63:0] RST_TMS  = 64'h1F;
  localparam int          TRST_LOW = 0;
`endif

  logic             sys_clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             rsp_ready = 1'b0;
  logic             tdo_loop = 1'b0;
  logic             tdo_val = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0]      cmd_data = '0;
  logic             cmd_ready, rsp_valid, tck, tms, tdi, trst, tdo;
  logic [31:0]      rsp_data;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  int trst_low = 0;
  logic tms_log[$];
  logic tdi_log[$];

  jtag_host_driver #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
  );

  assign tdo = tdo_loop ? tdi : tdo_val;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  always @(negedge sys_clk) if (trst === 1'b0) trst_low++;
  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    rises++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] pack_tms(input int base);
    logic [63:0] r;
    r = '0;
    for (int i = base; i < tms_log.size() && (i - base) < 64; i++) r[i-base] = tms_log[i];
    return r;
  endfunction

  function automatic logic [63:0] pack_tdi(input int base);
    logic [63:0] r;
    r = '0;
    for (int i = base; i < tdi_log.size() && (i - base) < 64; i++) r[i-base] = tdi_log[i];
    return r;
  endfunction

  // Present a command and wait for acceptance; t_acc = index of accepting edge.
  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len,
                       input logic [31:0] data, output int t_acc);
    int n;
    n = 0;
    @(negedge sys_clk);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge sys_clk); n++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
    end
    t_acc = cyc + 1;
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid (bounded), report latency and data, optionally consume it.
  task automatic wait_rsp(input int t_acc, input bit ack, output int lat, output logic [31:0] d);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (rsp_valid !== 1'b1 && n < 1000) begin @(negedge sys_clk); n++; end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b, required 1 within 1000 cycles", rsp_valid);
    end
    lat = cyc - t_acc;
    d = rsp_data;
    if (ack) begin
      rsp_ready = 1'b1;
      @(posedge sys_clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    int r0;
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    r0 = rises;
    repeat (4) @(negedge sys_clk);
    vectors++; if (tck !== 1'b0) begin errors++; $display("FAIL rst_tck: got %b want 0", tck); end
    vectors++; if (tms !== 1'b1) begin errors++; $display("FAIL rst_tms: got %b want 1", tms); end
    vectors++; if (tdi !== 1'b0) begin errors++; $display("FAIL rst_tdi: got %b want 0", tdi); end
    vectors++; if (trst !== 1'b1) begin errors++; $display("FAIL rst_trst: got %b want 1", trst); end
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    vectors++; if (rises != r0) begin errors++; $display("FAIL rst_tck_edges: got %0d want 0", rises - r0); end
    reset = 1'b0;
  endtask

  task automatic test_reset_cmd;
    int t, lat, r0, b, tl0;
    logic [31:0] d;
    r0 = rises; b = tms_log.size(); tl0 = trst_low;
    issue(2'b00, 6'd0, 32'hFFFF_FFFF, t);
    wait_rsp(t, 1'b1, lat, d);
    vectors++; if (lat != RST_TCK * 4) begin errors++; $display("FAIL reset_latency: got %0d want %0d", lat, RST_TCK * 4); end
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rsp: got %h want 0", d); end
    vectors++; if (rises - r0 != RST_TCK) begin errors++; $display("FAIL reset_tck_count: got %0d want %0d", rises - r0, RST_TCK); end
    vectors++; if (pack_tms(b) !== RST_TMS) begin errors++; $display("FAIL reset_tms: got %h want %h", pack_tms(b), RST_TMS); end
    vectors++; if (trst_low - tl0 != TRST_LOW) begin errors++; $display("FAIL reset_trst_low: got %0d want %0d", trst_low - tl0, TRST_LOW); end
  endtask

  task automatic test_ir_scan;
    int t, lat, r0, b;
    logic [31:0] d;
    tdo_loop = 1'b1;
    r0 = rises; b = tms_log.size();
    issue(2'b01, 6'd4, 32'h0000_000A, t);
    wait_rsp(t, 1'b1, lat, d);
    vectors++; if (pack_tms(b) !== 64'h183) begin errors++; $display("FAIL ir_tms: got %h want 183", pack_tms(b)); end
    vectors++; if (pack_tdi(b) !== 64'h0A0) begin errors++; $display("FAIL ir_tdi: got %h want 0a0", pack_tdi(b)); end
    vectors++; if (d !== 32'hA) begin errors++; $display("FAIL ir_rsp: got %h want 0000000a", d); end
    vectors++; if (rises - r0 != 10) begin errors++; $display("FAIL ir_tck_count: got %0d want 10", rises - r0); end
    vectors++; if (lat != 40) begin errors++; $display("FAIL ir_latency: got %0d want 40", lat); end
    tdo_loop = 1'b0;
  endtask

  task automatic test_dr_scan;
    int t, lat, r0, b;
    logic [31:0] d;
    logic [63:0] ti;
    logic [63:0] sh;
    tdo_val = 1'b1;
    r0 = rises; b = tms_log.size();
    issue(2'b10, 6'd32, 32'hDEAD_BEEF, t);
    wait_rsp(t, 1'b1, lat, d);
    ti = pack_tdi(b);
    sh = ti >> 3;
    vectors++; if (sh[7:0] !== 8'hEF) begin errors++; $display("FAIL dr_tdi_first8: got %h want ef", sh[7:0]); end
    vectors++; if (sh[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dr_tdi_all: got %h want deadbeef", sh[31:0]); end
    vectors++; if ((ti & 64'h18_0000_0007) !== 64'h0) begin errors++; $display("FAIL dr_tdi_outside: got %h want 0", ti & 64'h18_0000_0007); end
    vectors++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dr_rsp: got %h want ffffffff", d); end
    vectors++; if (rises - r0 != 37) begin errors++; $display("FAIL dr_tck_count: got %0d want 37", rises - r0); end
    vectors++; if (lat != 148) begin errors++; $display("FAIL dr_latency: got %0d want 148", lat); end
    tdo_val = 1'b0;
  endtask

  task automatic test_len_rules;
    int t, lat, r0, b;
    logic [31:0] d;
    tdo_loop = 1'b1;
    r0 = rises; b = tms_log.size();
    issue(2'b01, 6'd0, 32'h0000_0001, t);
    wait_rsp(t, 1'b1, lat, d);
    vectors++; if (pack_tms(b) !== 64'h33) begin errors++; $display("FAIL len0_tms: got %h want 33", pack_tms(b)); end
    vectors++; if (rises - r0 != 7) begin errors++; $display("FAIL len0_tck_count: got %0d want 7", rises - r0); end
    vectors++; if (d !== 32'h1) begin errors++; $display("FAIL len0_rsp: got %h want 00000001", d); end
    tdo_loop = 1'b0; tdo_val = 1'b1;
    r0 = rises;
    issue(2'b10, 6'd40, 32'h0, t);
    wait_rsp(t, 1'b1, lat, d);
    vectors++; if (rises - r0 != 37) begin errors++; $display("FAIL clamp_tck_count: got %0d want 37", rises - r0); end
    vectors++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL clamp_rsp: got %h want ffffffff", d); end
    tdo_val = 1'b0;
  endtask

  task automatic test_back_pressure;
    int t, lat, bad, r0, b;
    logic [31:0] d;
    tdo_loop = 1'b1;
    issue(2'b10, 6'd5, 32'hFFFF_FFF6, t);
    wait_rsp(t, 1'b0, lat, d);
    vectors++; if (d !== 32'h16) begin errors++; $display("FAIL bp_rsp_masked: got %h want 00000016", d); end
    tdo_loop = 1'b0;
    cmd_op = 2'b11; cmd_len = 6'd0; cmd_data = 32'h0; cmd_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h16 || cmd_ready !== 1'b0 || tck !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles, want 0 (rsp_valid=%b data=%h cmd_ready=%b tck=%b)", bad, rsp_valid, rsp_data, cmd_ready, tck); end
    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1 rsp_ready = 1'b0;
    @(negedge sys_clk);
    vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_drop: got %b want 0", rsp_valid); end
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_gap: cmd_ready got %b want 1", cmd_ready); end
    r0 = rises; b = tms_log.size();
    t = cyc + 1;
    @(negedge sys_clk);
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: cmd_ready got %b want 0", cmd_ready); end
    cmd_valid = 1'b0;
    wait_rsp(t, 1'b1, lat, d);
    vectors++; if (lat != 4) begin errors++; $display("FAIL idle_latency: got %0d want 4", lat); end
    vectors++; if (d !== 32'h0) begin errors++; $display("FAIL idle_rsp: got %h want 0", d); end
    vectors++; if (rises - r0 != 1 || pack_tms(b) !== 64'h0) begin errors++; $display("FAIL idle_tms: got %0d edges tms %h, want 1 edge tms 0", rises - r0, pack_tms(b)); end
  endtask

  task automatic test_reset_mid;
    int t, lat, r0, b, n;
    logic [31:0] d;
    logic [63:0] sh;
    tdo_val = 1'b0;
    r0 = rises;
    issue(2'b10, 6'd32, 32'hFFFF_FFFF, t);
    n = 0;
    while (rises - r0 < 14 && n < 500) begin @(negedge sys_clk); n++; end
    vectors++; if (rises - r0 != 14) begin errors++; $display("FAIL mid_reach_bit10: got %0d edges want 14", rises - r0); end
    reset = 1'b1;
    @(negedge sys_clk);
    vectors++; if (tck !== 1'b0 || tms !== 1'b1 || tdi !== 1'b0 || trst !== 1'b1) begin errors++; $display("FAIL mid_rst_pins: got tck=%b tms=%b tdi=%b trst=%b want 0 1 0 1", tck, tms, tdi, trst); end
    vectors++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL mid_rst_hs: got ready=%b valid=%b data=%h want 1 0 0", cmd_ready, rsp_valid, rsp_data); end
    reset = 1'b0;
    tdo_val = 1'b1;
    r0 = rises; b = tms_log.size();
    issue(2'b10, 6'd8, 32'h0000_005A, t);
    wait_rsp(t, 1'b1, lat, d);
    sh = pack_tdi(b) >> 9;
    vectors++; if (pack_tms(b) !== 64'h3005F) begin errors++; $display("FAIL resync_tms: got %h want 3005f", pack_tms(b)); end
    vectors++; if (rises - r0 != 19) begin errors++; $display("FAIL resync_tck_count: got %0d want 19", rises - r0); end
    vectors++; if (lat != 76) begin errors++; $display("FAIL resync_latency: got %0d want 76", lat); end
    vectors++; if (sh[7:0] !== 8'h5A) begin errors++; $display("FAIL resync_tdi: got %h want 5a", sh[7:0]); end
    vectors++; if (d !== 32'hFF) begin errors++; $display("FAIL resync_rsp: got %h want 000000ff", d); end
    tdo_val = 1'b0;
  endtask

  initial begin
    test_reset;
    test_reset_cmd;
    test_ir_scan;
    test_dr_scan;
    test_len_rules;
    test_back_pressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
